// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Stage indices along the in-order pipeline (bit position in stall/flush vectors)
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // Widest pipeline the mask helper supports (4-bit stage index)
    localparam int unsigned MAX_STAGES = 16;

    // Performance counter width
    localparam int unsigned PERF_W = 32;

    // Requester 1 holds at mem, requester 0 holds at if
    localparam logic [7:0] DEFAULT_STALL_POINTS = {4'(STG_MEM), 4'(STG_IF)};

    // Low-ones mask covering stages 0..idx: a stall at idx also holds every older stage
    function automatic logic [MAX_STAGES-1:0] stall_mask(input logic [3:0] idx);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_STAGES; k++) begin
            m[k] = (k <= 32'(idx));
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bus between the pipeline (master) and pipe_ctrl (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned NUM_REQ    = 2
);
    localparam int unsigned TW = $clog2(NUM_STAGES);

    logic                  rdy_in;
    logic [NUM_REQ-1:0]    stall_req;
    logic                  flush_req;
    logic [TW-1:0]         flush_tgt;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush_vec;
    logic                  flush_pending;
    logic                  stall_timeout;
    logic [PERF_W-1:0]     perf_stall_cycles;
    logic [PERF_W-1:0]     perf_flush_count;

    modport master (
        output rdy_in, stall_req, flush_req, flush_tgt,
        input  stall, flush_vec, flush_pending, stall_timeout,
               perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  rdy_in, stall_req, flush_req, flush_tgt,
        output stall, flush_vec, flush_pending, stall_timeout,
               perf_stall_cycles, perf_flush_count
    );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled ready cycles, raises a sticky flag at TIMEOUT.
module pipe_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy_i,
    input  logic stalled_i,
    output logic timeout_o
);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;

    // Next count: clear when nothing is held, advance on ready stalled cycles, saturate
    always_comb begin
        wd_d = wd_q;
        if (!stalled_i) begin
            wd_d = '0;
        end else if (rdy_i && (wd_q != WW'(TIMEOUT))) begin
            wd_d = wd_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_d == WW'(TIMEOUT));
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stall requests into a per-stage hold vector,
// issues or queues flushes, and hosts the stall watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned           NUM_STAGES   = 6,
    parameter int unsigned           NUM_REQ      = 2,
    parameter logic [4*NUM_REQ-1:0]  STALL_POINTS = DEFAULT_STALL_POINTS,
    parameter int unsigned           TIMEOUT      = 1024
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    localparam int unsigned TW = $clog2(NUM_STAGES);

    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  pend_v_q, pend_v_d;
    logic [TW-1:0]         pend_tgt_q, pend_tgt_d;
    logic                  eff_v;
    logic [TW-1:0]         eff_tgt;
    logic                  next_held;
    logic                  issue;
    logic                  timeout;

    // Stall vector: union of requester masks; forced all-ones while paused, zero in reset
    always_comb begin
        logic [MAX_STAGES-1:0] m;
        logic [NUM_STAGES-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            m = stall_mask(STALL_POINTS[4*i +: 4]);
            if (bus.stall_req[i]) begin
                acc = acc | m[NUM_STAGES-1:0];
            end
        end
        if (rst) begin
            stall_c = '0;
        end else if (!bus.rdy_in) begin
            stall_c = '1;
        end else begin
            stall_c = acc;
        end
    end

    // Effective flush: new request merged with the queued one by taking the older boundary
    always_comb begin
        eff_v   = pend_v_q | bus.flush_req;
        eff_tgt = bus.flush_tgt;
        if (pend_v_q) begin
            if (bus.flush_req && (bus.flush_tgt > pend_tgt_q)) begin
                eff_tgt = bus.flush_tgt;
            end else begin
                eff_tgt = pend_tgt_q;
            end
        end
    end

    // Issue check: the stage producing the flush (one beyond the boundary) must not be held
    always_comb begin
        next_held = 1'b0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            if (k == 32'(eff_tgt) + 1) begin
                next_held = stall_c[k];
            end
        end
        issue = !rst && bus.rdy_in && eff_v &&
                ((32'(eff_tgt) >= NUM_STAGES - 1) || !next_held);
        flush_c = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            flush_c[k] = issue && (k <= 32'(eff_tgt));
        end
    end

    // Queue update: an issued flush empties the slot, a blocked one parks the merged entry
    always_comb begin
        pend_v_d   = eff_v & ~issue;
        pend_tgt_d = eff_v ? eff_tgt : pend_tgt_q;
    end

    // Single-entry flush queue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    pipe_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .rdy_i     (bus.rdy_in),
        .stalled_i (|stall_c),
        .timeout_o (timeout)
    );

    assign bus.stall         = stall_c;
    assign bus.flush_vec     = flush_c;
    assign bus.flush_pending = pend_v_q;
    assign bus.stall_timeout = timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    // Counter increments: ready stalled cycles and issued flushes, both wrapping
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (bus.rdy_in && (|stall_c)) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
        if (issue) begin
            perf_flush_d = perf_flush_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_flush_count  = perf_flush_q;
`else
    assign bus.perf_stall_cycles = '0;
    assign bus.perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of stall/flush/watchdog/perf rules.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned TO = 16;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if #(.NUM_STAGES(6), .NUM_REQ(2)) bus_if ();

    pipe_ctrl #(
        .NUM_STAGES   (6),
        .NUM_REQ      (2),
        .STALL_POINTS ({4'd4, 4'd1}),
        .TIMEOUT      (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int  pt [2] = '{1, 4};
    bit  m_pv;
    int  m_pt;
    int  m_wd;
    bit  m_to;
    int unsigned m_ps;
    int unsigned m_pf;

    logic [5:0] obs_stall;
    logic [5:0] obs_fv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers
    task automatic step(input bit r, input bit rdy, input bit [1:0] req,
                        input bit fr, input int ft);
        int e_stall, e_fv, eff_t;
        bit eff_v, iss;
        @(negedge clk);
        rst              = r;
        bus_if.rdy_in    = rdy;
        bus_if.stall_req = req;
        bus_if.flush_req = fr;
        bus_if.flush_tgt = 3'(ft);
        #1;
        e_stall = 0;
        if (!r) begin
            if (!rdy) e_stall = 63;
            else
                for (int i = 0; i < 2; i++)
                    if (req[i]) e_stall = e_stall | ((1 << (pt[i] + 1)) - 1);
        end
        eff_v = m_pv || fr;
        if (m_pv) eff_t = (fr && ft > m_pt) ? ft : m_pt;
        else      eff_t = ft;
        iss  = !r && rdy && eff_v && (eff_t >= 5 || ((e_stall >> (eff_t + 1)) & 1) == 0);
        e_fv = iss ? (((1 << (eff_t + 1)) - 1) & ~1) : 0;
        obs_stall = bus_if.stall;
        obs_fv    = bus_if.flush_vec;
        chk("stall", 32'(obs_stall), 32'(e_stall));
        chk("flush_vec", 32'(obs_fv), 32'(e_fv));
        if (r) begin
            m_pv = 0; m_pt = 0; m_wd = 0; m_to = 0; m_ps = 0; m_pf = 0;
        end else begin
            if (iss) begin
                m_pv = 0;
                m_pf++;
            end else if (eff_v) begin
                m_pv = 1;
                m_pt = eff_t;
            end
            if (e_stall == 0) m_wd = 0;
            else if (rdy && m_wd < TO) m_wd++;
            if (m_wd >= TO) m_to = 1;
            if (rdy && e_stall != 0) m_ps++;
        end
        @(posedge clk);
        #1;
        chk("flush_pending", 32'(bus_if.flush_pending), 32'(m_pv));
        chk("stall_timeout", 32'(bus_if.stall_timeout), 32'(m_to));
        chk("perf_stall", bus_if.perf_stall_cycles, PERF ? m_ps : 0);
        chk("perf_flush", bus_if.perf_flush_count, PERF ? m_pf : 0);
    endtask

    initial begin
        bit [1:0] rq;
        bus_if.rdy_in    = 1'b1;
        bus_if.stall_req = '0;
        bus_if.flush_req = 1'b0;
        bus_if.flush_tgt = '0;

        // Reset values
        step(1, 1, 2'b00, 0, 0);
        step(1, 1, 2'b11, 1, 3);

        // Stall masks
        step(0, 1, 2'b01, 0, 0);
        chk("plan_stall_if", 32'(obs_stall), 32'h03);
        step(0, 1, 2'b11, 0, 0);
        chk("plan_stall_both", 32'(obs_stall), 32'h1f);

        // Flush during pause, issued on first ready cycle
        step(0, 0, 2'b00, 1, 2);
        chk("plan_pause_stall", 32'(obs_stall), 32'h3f);
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        chk("plan_pause_pending", 32'(bus_if.flush_pending), 32'd1);
        step(0, 1, 2'b00, 0, 0);
        chk("plan_pause_issue", 32'(obs_fv), 32'h06);
        chk("plan_pause_clear", 32'(bus_if.flush_pending), 32'd0);

        // Flush deferred behind a mem stall
        for (int c = 0; c < 4; c++) step(0, 1, 2'b10, c == 0, 3);
        chk("plan_defer_held", 32'(obs_fv), 32'h00);
        step(0, 1, 2'b00, 0, 0);
        chk("plan_defer_issue", 32'(obs_fv), 32'h0e);
        step(0, 1, 2'b00, 0, 0);
        chk("plan_defer_once", 32'(obs_fv), 32'h00);

        // Pending entry merged with a newer, older-boundary request
        step(0, 1, 2'b10, 1, 2);
        step(0, 1, 2'b10, 1, 4);
        chk("plan_merge_issue", 32'(obs_fv), 32'h1e);
        step(0, 1, 2'b00, 0, 0);
        chk("plan_merge_single", 32'(obs_fv), 32'h00);

        // Watchdog: sets on the TO-th stalled cycle and is sticky
        step(1, 1, 2'b00, 0, 0);
        for (int c = 0; c < TO - 1; c++) step(0, 1, 2'b01, 0, 0);
        chk("wd_early", 32'(bus_if.stall_timeout), 32'd0);
        step(0, 1, 2'b01, 0, 0);
        chk("wd_set", 32'(bus_if.stall_timeout), 32'd1);
        for (int c = 0; c < 3; c++) step(0, 1, 2'b00, 0, 0);
        chk("wd_sticky", 32'(bus_if.stall_timeout), 32'd1);
        step(1, 1, 2'b00, 0, 0);
        chk("wd_reset", 32'(bus_if.stall_timeout), 32'd0);

        // Stalled cycles with pauses, then reset mid-stall with a queued flush
        step(0, 1, 2'b01, 0, 0);
        step(0, 0, 2'b01, 0, 0);
        step(0, 1, 2'b01, 0, 0);
        step(0, 0, 2'b01, 0, 0);
        step(0, 1, 2'b01, 0, 0);
        chk("perf_three", bus_if.perf_stall_cycles, PERF ? 32'd3 : 32'd0);
        step(0, 1, 2'b10, 1, 3);
        step(1, 1, 2'b10, 0, 0);
        chk("rst_pending", 32'(bus_if.flush_pending), 32'd0);

        // Randomized traffic
        rq = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3, 0) == 0) rq = 2'($urandom);
            step($urandom_range(99, 0) == 0,
                 $urandom_range(7, 0) != 0,
                 rq,
                 $urandom_range(4, 0) == 0,
                 int'($urandom_range(5, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the in-order RISC-V core. It merges N prioritised stall requests into a per-stage hold vector and converts flush requests into a per-stage flush vector. A flush is deferred while its producing stage is held, and a flush that arrives during a global pause is queued. A stall watchdog and optional performance counters complete the block. It sits beside the pc/if/id/ex/mem/wb pipeline and drives every stage's hold and flush inputs.

## Interface
- NUM_STAGES, 6: pipeline stages; bit 0 = pc, bit NUM_STAGES-1 = wb.
- NUM_REQ, 2: stall requesters.
- STALL_POINTS, {4'd4, 4'd1}: packed 4-bit stage index per requester, entry i at [4i+3:4i]. The default gives mem→4 (req 1) and if→1 (req 0).
- TIMEOUT, 1024: consecutive stalled cycles before stall_timeout sets.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global ready; low pauses the whole pipeline.
- stall_req  in  NUM_REQ  bit i = requester i asks for a stall.
- flush_req  in  1  single-cycle flush request.
- flush_tgt  in  $clog2(NUM_STAGES)  youngest-to-oldest flush boundary; stages 1..flush_tgt are flushed.
- stall  out  NUM_STAGES  per-stage hold.
- flush_vec  out  NUM_STAGES  per-stage flush; bit 0 is always 0.
- flush_pending  out  1  a flush is queued.
- stall_timeout  out  1  sticky watchdog flag.
- perf_stall_cycles  out  32  stalled-cycle count.
- perf_flush_count  out  32  issued-flush count.

## Operation
- Requester mask: m_i = (1 << (P_i+1)) - 1 when stall_req[i] is set, else 0.
- stall: combinational. It is OR of all m_i. It is all ones when rdy_in=0, and all zeros while rst=1.
- Flush queue: one entry, holding pend_v and pend_tgt.
  - flush_req=1 captures flush_tgt.
  - If pend_v is already set, pend_tgt becomes max(pend_tgt, flush_tgt).
- Effective request: eff_v = pend_v | flush_req, and eff_tgt = the merged max.
- Issue condition: rdy_in=1, eff_v=1, and either eff_tgt = NUM_STAGES-1 or stall[eff_tgt+1]=0.
- On issue:
  - flush_vec[k] = 1 for 1 ≤ k ≤ eff_tgt, combinationally in the same cycle.
  - pend_v clears at the next edge, unless a new flush_req arrives in the issue cycle after the issued one was merged. Merging makes this impossible, so pend_v simply clears.
- When the issue condition fails, eff is written to pend, flush_vec=0, and flush_pending=1.
- Flushed stages give flush priority over their own stall bit. The controller does not alter stall.
- Watchdog:
  - Counter wd increments when rdy_in=1 and stall≠0, and clears when stall=0.
  - wd holds when rdy_in=0.
  - stall_timeout sets when wd reaches TIMEOUT. It stays set until rst; wd saturates.

## Timing
- stall and flush_vec are zero-latency combinational. flush_pending is registered and reflects the queue state after the edge.
- A deferred flush issues in the first cycle in which the issue condition holds; the minimum deferral is 1 cycle.
- Simultaneous flush_req and issuable pending entry: one merged flush with the max target, counted once.
- Reset mid-operation: the pending flush is discarded, wd=0, stall_timeout=0, and the perf counters are 0.
- Reset values: stall=0, flush_vec=0, flush_pending=0, stall_timeout=0, perf_*=0.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cycles increments, with wrap, in every cycle where rdy_in=1 and stall≠0.
  - perf_flush_count increments on each issued flush.
- PIPE_CTRL_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- pipe_ctrl_pkg holds:
  - the stage index constants STG_PC=0, STG_IF=1, STG_ID=2, STG_EX=3, STG_MEM=4, STG_WB=5;
  - the default STALL_POINTS;
  - a function stall_mask(idx) returning the low-ones mask.
- Sub-module pipe_ctrl_wdog holds the watchdog counter and sticky flag, parametrised by TIMEOUT.

## Test plan
- Default params, stall_req=2'b01 → stall=6'b000011. stall_req=2'b11 → 6'b011111.
- rdy_in=0 for 3 cycles with flush_req=1, tgt=2 in the first cycle → stall=6'b111111, flush_vec=0, flush_pending=1. On the first cycle with rdy_in=1 → flush_vec=6'b000110, and flush_pending=0 after that edge.
- stall_req[1]=1 for 4 cycles, flush_req tgt=3 in cycle 0 → deferred. In the cycle stall_req drops → flush_vec=6'b001110, issued once.
- Pending tgt=2 plus a new flush_req tgt=4 while deferred → single issue flush_vec=6'b011110; perf_flush_count +1.
- TIMEOUT=8, stall_req[0] held 10 cycles → stall_timeout rises after the 8th stalled cycle and stays high after the request drops. rst → 0.
- With PIPE_CTRL_PERF_EN, 5 stalled cycles of which 2 have rdy_in=0 → perf_stall_cycles=3. rst mid-stall → all outputs 0 on the next cycle.
